data_mem_bridge: RTL

DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

---
 rtl/data_mem_bridge_pkg.sv | 24 ++
 rtl/data_mem_bridge_clear_seq.sv | 51 +++++
 rtl/data_mem_bridge.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/data_mem_bridge_pkg.sv
// ============================================================================
// Module   : data_mem_bridge_pkg
// Purpose  : Shared state encoding and BRAM timing constants for the data
//            memory bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_bridge_pkg;

    localparam int unsigned            c_STATE_W  = 1;
    localparam logic [c_STATE_W-1:0]   c_ST_CLEAR = 1'b0;
    localparam logic [c_STATE_W-1:0]   c_ST_RUN   = 1'b1;

    // Registered BRAM output: data for an access in cycle N appears in N+1.
    localparam int unsigned            c_BRAM_RD_LATENCY = 1;

    function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word_idx);
        return {word_idx[29:0], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_bridge_clear_seq.sv
// ============================================================================
// Module   : mem_clear_seq
// Purpose  : Word-by-word zero-fill sweeper; runs from reset or a start pulse
//            through DEPTH words, one word per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_clear_seq #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             active,
    output logic [IDX_W-1:0] word_idx,
    output logic             done
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DEPTH - 1);

    logic             r_active;
    logic [IDX_W-1:0] r_idx;
    logic             w_last;

    assign w_last   = r_active && (r_idx == c_LAST_IDX);
    assign active   = r_active;
    assign word_idx = r_idx;
    assign done     = w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b1;
            r_idx    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_idx    <= '0;
        end else if (r_active) begin
            if (w_last) begin
                r_active <= 1'b0;
                r_idx    <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_bridge.sv
// ============================================================================
// Module   : data_mem_bridge
// Purpose  : Core data-port to BRAM port-B bridge with zero-fill on reset or
//            clear, out-of-range error responses and a tohost pass mailbox.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_bridge
    import data_mem_bridge_pkg::*;
#(
    parameter int unsigned MEM_DEPTH     = 4096,
    parameter logic [31:0] TOHOST_OFFSET = 32'h0000_3FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic [31:0] mem_offset_i,
    input  logic [31:0] success_code_i,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        data_mem_clkb,
    output logic        data_mem_enb,
    output logic        data_mem_rstb,
    output logic [3:0]  data_mem_web,
    output logic [31:0] data_mem_addrb,
    output logic [31:0] data_mem_dinb,
    input  logic [31:0] data_mem_doutb,
    input  logic        data_mem_rstb_busy,
    output logic        busy_o,
    output logic        stop_o
);

    localparam int unsigned c_IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [32:0] c_MEM_BYTES = 33'(MEM_DEPTH) << 2;

    generate
        if (c_BRAM_RD_LATENCY != 1) begin : g_latency_guard
            $error("data_mem_bridge response path assumes a 1-cycle BRAM read latency");
        end
    endgenerate

    logic [c_STATE_W-1:0] r_state;
    logic                 r_rvalid;
    logic                 r_err;
    logic                 r_stop;

    logic                 w_clr_active;
    logic                 w_clr_done;
    logic [c_IDX_W-1:0]   w_clr_idx;
    logic [31:0]          w_local;
    logic                 w_in_range;
    logic                 w_gnt;
    logic                 w_tohost_hit;
    logic                 w_unused_rstb_busy;

    assign w_unused_rstb_busy = data_mem_rstb_busy;

    mem_clear_seq #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (c_IDX_W)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .start    (clear_i),
        .active   (w_clr_active),
        .word_idx (w_clr_idx),
        .done     (w_clr_done)
    );

    // Wrap-around subtraction makes addresses below the offset huge, so a
    // single unsigned compare rejects both sides of the window.
    assign w_local    = data_addr_i - mem_offset_i;
    assign w_in_range = ({1'b0, w_local} < c_MEM_BYTES);
    assign w_gnt      = data_req_i && (r_state == c_ST_RUN) && !clear_i;

    assign w_tohost_hit = w_gnt && w_in_range && data_we_i
                          && (w_local[31:2] == TOHOST_OFFSET[31:2])
                          && (data_be_i == 4'hF)
                          && (data_wdata_i == success_code_i);

    always_comb begin
        data_mem_enb   = 1'b0;
        data_mem_web   = 4'h0;
        data_mem_addrb = 32'h0;
        data_mem_dinb  = 32'h0;
        if (w_clr_active) begin
            data_mem_enb   = 1'b1;
            data_mem_web   = 4'hF;
            data_mem_addrb = word_to_byte_addr(32'(w_clr_idx));
        end else if (w_gnt && w_in_range) begin
            data_mem_enb   = 1'b1;
            data_mem_web   = data_we_i ? data_be_i : 4'h0;
            data_mem_addrb = {w_local[31:2], 2'b00};
            data_mem_dinb  = data_wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_CLEAR;
        end else if (clear_i) begin
            r_state <= c_ST_CLEAR;
        end else if ((r_state == c_ST_CLEAR) && w_clr_done) begin
            r_state <= c_ST_RUN;
        end
    end

    // A response launched before clear_i still drains: it only depends on w_gnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_stop   <= 1'b0;
        end else begin
            r_rvalid <= w_gnt;
            r_err    <= w_gnt && !w_in_range;
            if (w_tohost_hit) begin
                r_stop <= 1'b1;
            end
        end
    end

    assign data_gnt_o    = w_gnt;
    assign data_rvalid_o = r_rvalid;
    assign data_err_o    = r_err;
    assign data_rdata_o  = (r_rvalid && !r_err) ? data_mem_doutb : 32'h0;
    assign data_mem_clkb = clk;
    assign data_mem_rstb = 1'b0;
    assign busy_o        = (r_state == c_ST_CLEAR);
    assign stop_o        = r_stop;

endmodule

`default_nettype wire
